// File: rtl/slice_collector.sv
// Gathers 64 permutation slices, then streams the transposed state as 25 lanes (first lane 1 cycle after last slice).
// Lanes advance only on laneAck; slice strobes outside collection are dropped.
module slice_collector #(
  parameter int N     = 5,
  parameter int Count = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inValid,
  input  logic [N*N-1:0]             sliceIn,
  output logic                       ready,
  output logic [$clog2(Count)-1:0]   sliceCnt,
  output logic                       laneValid,
  input  logic                       laneAck,
  output logic [$clog2(N*N)-1:0]     laneIdx,
  output logic [Count-1:0]           laneOut,
  output logic                       done
);

  localparam int NN = N * N;
  localparam int CW = $clog2(Count);
  localparam int LW = $clog2(NN);
  localparam logic [CW-1:0] LAST_SLICE = CW'(Count - 1);
  localparam logic [LW-1:0] LAST_LANE  = LW'(NN - 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_EMIT    = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NN-1:0]   r_buf [Count];
  logic [CW-1:0]   r_slice_cnt;
  logic [LW-1:0]   r_lane_idx;
  logic            w_wr;
  logic            w_lane_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    laneValid   = 1'b0;
    done        = 1'b0;
    w_wr        = 1'b0;
    w_lane_adv  = 1'b0;
    case (r_state)
      S_COLLECT: begin
        ready = 1'b1;
        w_wr  = inValid;
        if (inValid && (r_slice_cnt == LAST_SLICE)) begin
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        laneValid  = 1'b1;
        w_lane_adv = laneAck;
        if (laneAck && (r_lane_idx == LAST_LANE)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_COLLECT;
      end
      default: begin
        w_state_nxt = S_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slice_cnt <= '0;
      r_lane_idx  <= '0;
    end else begin
      if (w_wr) begin
        r_slice_cnt <= (r_slice_cnt == LAST_SLICE) ? '0 : r_slice_cnt + CW'(1);
      end
      if (w_lane_adv) begin
        r_lane_idx <= (r_lane_idx == LAST_LANE) ? '0 : r_lane_idx + LW'(1);
      end
    end
  end

  // Reset clears the buffer so a discarded frame can never leak into laneOut.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int z = 0; z < Count; z++) begin
        r_buf[z] <= '0;
      end
    end else if (w_wr) begin
      r_buf[r_slice_cnt] <= sliceIn;
    end
  end

  always_comb begin
    laneOut = '0;
    for (int z = 0; z < Count; z++) begin
      laneOut[z] = r_buf[z][r_lane_idx];
    end
  end

  assign sliceCnt = r_slice_cnt;
  assign laneIdx  = r_lane_idx;

endmodule

// File: tb/tb_slice_collector.sv
// Randomized and directed frames checked every cycle against a queue-based transpose model.
module tb_slice_collector;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic [24:0] sliceIn;
  logic        ready;
  logic [5:0]  sliceCnt;
  logic        laneValid;
  logic        laneAck;
  logic [4:0]  laneIdx;
  logic [63:0] laneOut;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  bit run_chk  = 0;

  logic [24:0] m_frame [$];
  logic [63:0] m_lanes [25];
  int          m_phase;
  int          m_lane;
  logic [63:0] lane_seen [25];

  slice_collector #(.N(5), .Count(64)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .sliceIn(sliceIn),
    .ready(ready), .sliceCnt(sliceCnt), .laneValid(laneValid),
    .laneAck(laneAck), .laneIdx(laneIdx), .laneOut(laneOut), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 collecting, 1 presenting lanes, 2 done pulse.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_lane  = 0;
      m_frame.delete();
    end else begin
      case (m_phase)
        0: if (inValid) begin
          m_frame.push_back(sliceIn);
          if (m_frame.size() == 64) begin
            for (int i = 0; i < 25; i++)
              for (int z = 0; z < 64; z++)
                m_lanes[i][z] = m_frame[z][i];
            m_frame.delete();
            m_phase = 1;
            m_lane  = 0;
          end
        end
        1: if (laneAck) begin
          if (m_lane == 24) begin
            m_lane  = 0;
            m_phase = 2;
          end else begin
            m_lane++;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (run_chk && !rst) begin
      chk("ready", 64'(ready), 64'(m_phase == 0));
      chk("laneValid", 64'(laneValid), 64'(m_phase == 1));
      chk("done", 64'(done), 64'(m_phase == 2));
      chk("sliceCnt", 64'(sliceCnt), 64'(m_frame.size()));
      chk("laneIdx", 64'(laneIdx), 64'(m_lane));
      if (m_phase == 1) chk("laneOut", laneOut, m_lanes[m_lane]);
      if (done) done_cnt++;
      if (laneValid && laneAck) lane_seen[laneIdx] = laneOut;
    end
  end

  function automatic logic [24:0] slice_val(input int pat, input int z);
    logic [24:0] v;
    case (pat)
      0:       v = z[0] ? 25'h0AAAAAA : 25'h1555555;
      1:       v = 25'd1 << (z % 25);
      default: v = 25'($urandom);
    endcase
    return v;
  endfunction

  task automatic drive_frame(input int pat, input int nsl, input int max_gap,
                             input int bp_lane, input bit rand_ack, output int done_cyc);
    int first_edge;
    int n;
    bit held;
    done_cyc   = 0;
    held       = 0;
    first_edge = 0;
    laneAck    = 1'b1;
    for (int z = 0; z < nsl; z++) begin
      if (max_gap > 0 && z > 0) begin
        inValid = 1'b0;
        repeat ($urandom_range(1, max_gap)) begin
          @(posedge clk); #1;
        end
      end
      inValid = 1'b1;
      sliceIn = slice_val(pat, z);
      if (z == 0) first_edge = cyc + 1;
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    if (nsl < 64) return;
    n = 0;
    while (!done && n < 400) begin
      if (rand_ack) begin
        laneAck = 1'($urandom_range(0, 1));
        inValid = 1'($urandom_range(0, 1));
        sliceIn = 25'($urandom);
      end else if (bp_lane >= 0 && !held && int'(laneIdx) == bp_lane) begin
        held    = 1;
        laneAck = 1'b0;
        for (int k = 0; k < 10; k++) begin
          inValid = k[0];
          sliceIn = 25'($urandom);
          @(posedge clk); #1;
          n++;
        end
        inValid = 1'b0;
        laneAck = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    inValid = 1'b0;
    laneAck = 1'b1;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=0 expected=1 t=%0t", $time);
    end else begin
      done_cyc = cyc - first_edge + 2;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int dc;
    int d0;
    rst     = 1'b1;
    inValid = 1'b0;
    laneAck = 1'b0;
    sliceIn = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_laneValid", 64'(laneValid), 64'd0);
    chk("rst_laneOut", laneOut, 64'd0);
    rst     = 1'b0;
    run_chk = 1;

    // Checkerboard, no gaps, ack held high.
    d0 = done_cnt;
    drive_frame(0, 64, 0, -1, 0, dc);
    chk("cb_done_cycle", 64'(dc), 64'd90);
    chk("cb_done_once", 64'(done_cnt - d0), 64'd1);
    chk("cb_lane0", lane_seen[0], 64'h5555555555555555);
    chk("cb_lane1", lane_seen[1], 64'hAAAAAAAAAAAAAAAA);
    chk("cb_lane24", lane_seen[24], 64'h5555555555555555);

    // One-hot with 1-3 cycle gaps.
    drive_frame(1, 64, 3, -1, 0, dc);
    chk("oh_lane0", lane_seen[0], 64'h0004_0000_0200_0001);
    chk("oh_lane1", lane_seen[1], 64'h0008_0000_0400_0002);
    chk("oh_lane24", lane_seen[24], 64'h0002_0000_0100_0000);

    // Backpressure on lane 3 with junk strobes.
    drive_frame(0, 64, 0, 3, 0, dc);
    chk("bp_lane3", lane_seen[3], 64'hAAAAAAAAAAAAAAAA);
    chk("bp_lane4", lane_seen[4], 64'h5555555555555555);

    // Abort after 30 slices, then a full frame and a back-to-back one.
    drive_frame(1, 30, 2, -1, 0, dc);
    rst = 1'b1;
    #3;
    rst = 1'b0;
    chk("abort_sliceCnt", 64'(sliceCnt), 64'd0);
    drive_frame(0, 64, 0, -1, 0, dc);
    chk("abort_lane2", lane_seen[2], 64'h5555555555555555);
    drive_frame(1, 64, 0, -1, 0, dc);
    chk("b2b_lane0", lane_seen[0], 64'h0004_0000_0200_0001);

    for (int f = 0; f < 4; f++) begin
      drive_frame(2, 64, $urandom_range(0, 2), -1, 1, dc);
    end

    // Asynchronous reset in the middle of lane output.
    for (int z = 0; z < 64; z++) begin
      inValid = 1'b1;
      sliceIn = 25'($urandom);
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    laneAck = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    laneAck = 1'b0;
    chk("pre_rst_laneIdx", 64'(laneIdx), 64'd4);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(ready), 64'd1);
    chk("mid_rst_laneValid", 64'(laneValid), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_sliceCnt", 64'(sliceCnt), 64'd0);
    chk("mid_rst_laneIdx", 64'(laneIdx), 64'd0);
    chk("mid_rst_laneOut", laneOut, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_frame(1, 64, 1, -1, 0, dc);
    chk("post_rst_lane1", lane_seen[1], 64'h0008_0000_0400_0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
